// File: rtl/filtr_pkg.sv
// ---------------------------------------------------------------------------
// filtr_pkg
// Shared definitions for the adaptive-filter sequencer slice:
//   - state_t        : sequencer states (IDLE, LOAD, FILT, ADAPT, OUT)
//   - DATA_SIZE_DEF  : default sample / result width
//   - TIMEOUT_CYC_DEF: default hang limit for the FILT / ADAPT waits
//   - is_drop_state  : states in which a new strobe is dropped (overrun)
//   - is_wait_state  : states waiting on a datapath completion pulse
// ---------------------------------------------------------------------------
package filtr_pkg;

    localparam int DATA_SIZE_DEF   = 24;
    localparam int TIMEOUT_CYC_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILT  = 3'd2,
        ST_ADAPT = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // A strobe is only accepted in IDLE or OUT; anywhere else it is lost.
    function automatic logic is_drop_state(input state_t s);
        return (s == ST_LOAD) || (s == ST_FILT) || (s == ST_ADAPT);
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FILT) || (s == ST_ADAPT);
    endfunction

endpackage

// File: rtl/filtr_strobe_sync.sv
// ---------------------------------------------------------------------------
// filtr_strobe_sync
// Brings the (possibly asynchronous) sample strobe into the clk domain with a
// two-flop synchroniser and emits a one-cycle pulse on its rising edge.
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous active-high reset
//   sample_async in  raw strobe, at least two clk periods wide
//   rise         out one-cycle pulse, high the cycle after the strobe is
//                    seen by the second synchroniser stage
// ---------------------------------------------------------------------------
module filtr_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic sample_async,
    output logic rise
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= sample_async;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // s3 is only an edge-history register; s1/s2 form the synchroniser.
    assign rise = s2_reg & ~s3_reg;

endmodule

// File: rtl/filtr_sekwencer.sv
// ---------------------------------------------------------------------------
// filtr_sekwencer
// Per-sample sequencer sitting above the adaptive filter core. For each
// synchronised sample strobe it captures data_in, pulses filt_start, waits
// for filt_done, optionally runs a coefficient update (adapt_start /
// adapt_done) and publishes the result with a one-cycle data_valid.
// Strobes arriving while the datapath is busy are counted as overruns.
//
// Build option: define FILTR_TIMEOUT_EN to add a hang timer on the FILT and
// ADAPT waits; otherwise those waits are unbounded and err_timeout is 0.
//
// Ports:
//   clk, reset        clock / asynchronous active-high reset
//   sample, data_in   strobe (async) and the sample it qualifies
//   adapt_en          run a coefficient update after this filter pass
//   ovr_clr           clears overrun and ovr_cnt (wins over a same-cycle drop)
//   filt_start/filt_x start pulse and captured sample to the filter core
//   filt_done/filt_y  completion pulse and result from the filter core
//   adapt_start/done  coefficient update handshake
//   data_out/valid    last published result and its update pulse
//   busy              sequencer not idle
//   overrun, ovr_cnt  sticky drop flag and saturating drop count
//   sample_cnt        published-sample count (wraps)
//   err_timeout       sticky hang flag
// ---------------------------------------------------------------------------
module filtr_sekwencer
    import filtr_pkg::*;
#(
    parameter int DATA_SIZE   = DATA_SIZE_DEF,
    parameter int CNT_W       = 16,
    parameter int OVR_W       = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 adapt_en,
    input  logic                 ovr_clr,
    output logic                 filt_start,
    output logic [DATA_SIZE-1:0] filt_x,
    input  logic                 filt_done,
    input  logic [DATA_SIZE-1:0] filt_y,
    output logic                 adapt_start,
    input  logic                 adapt_done,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic [OVR_W-1:0]     ovr_cnt,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic                 err_timeout
);

    state_t               state_reg;
    state_t               state_next;
    logic                 rise;
    logic                 capture;
    logic                 drop;
    logic                 timeout_hit;
    logic                 adapt_first_reg;
    logic [DATA_SIZE-1:0] filt_x_reg;
    logic [DATA_SIZE-1:0] data_out_reg;
    logic                 overrun_reg;
    logic [OVR_W-1:0]     ovr_cnt_reg;
    logic [CNT_W-1:0]     sample_cnt_reg;

    filtr_strobe_sync u_sync (
        .clk          (clk),
        .reset        (reset),
        .sample_async (sample),
        .rise         (rise)
    );

    // A strobe in OUT is accepted directly, so back-to-back samples need
    // not pass through IDLE.
    assign capture = rise && ((state_reg == ST_IDLE) || (state_reg == ST_OUT));
    assign drop    = rise && is_drop_state(state_reg);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // ---------------- next-state logic ----------------
    // Completion pulses are only looked at in their own wait state; a done
    // arriving in the same cycle as a timeout takes priority.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (rise) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_FILT;
            ST_FILT: begin
                if (filt_done)        state_next = adapt_en ? ST_ADAPT : ST_OUT;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_ADAPT: begin
                if (adapt_done)       state_next = ST_OUT;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_OUT:   state_next = rise ? ST_LOAD : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        filt_start  = (state_reg == ST_LOAD);
        adapt_start = (state_reg == ST_ADAPT) && adapt_first_reg;
        data_valid  = (state_reg == ST_OUT);
        busy        = (state_reg != ST_IDLE);
    end

    // ---------------- datapath / counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adapt_first_reg <= 1'b0;
            filt_x_reg      <= '0;
            data_out_reg    <= '0;
            overrun_reg     <= 1'b0;
            ovr_cnt_reg     <= '0;
            sample_cnt_reg  <= '0;
        end else begin
            // Marks the first ADAPT cycle so adapt_start is a single pulse.
            adapt_first_reg <= (state_reg == ST_FILT) && (state_next == ST_ADAPT);

            if (capture) filt_x_reg <= data_in;

            if ((state_reg == ST_FILT) && filt_done) data_out_reg <= filt_y;

            if (state_reg == ST_OUT) sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);

            if (ovr_clr) begin
                overrun_reg <= 1'b0;
                ovr_cnt_reg <= '0;
            end else if (drop) begin
                overrun_reg <= 1'b1;
                if (ovr_cnt_reg != '1) ovr_cnt_reg <= ovr_cnt_reg + OVR_W'(1);
            end
        end
    end

    assign filt_x     = filt_x_reg;
    assign data_out   = data_out_reg;
    assign overrun    = overrun_reg;
    assign ovr_cnt    = ovr_cnt_reg;
    assign sample_cnt = sample_cnt_reg;

`ifdef FILTR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             err_timeout_reg;

    // Fires in the TIMEOUT_CYC-th consecutive cycle of a wait state.
    assign timeout_hit = is_wait_state(state_reg) &&
                         (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_reg     <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            // Any state change (including FILT -> ADAPT) restarts the count.
            if (state_next != state_reg)       tmo_cnt_reg <= '0;
            else if (is_wait_state(state_reg)) tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);

            // The only way out of a wait state to IDLE is the timeout.
            if (is_wait_state(state_reg) && (state_next == ST_IDLE))
                err_timeout_reg <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_reg;
`else
    // The limit only matters for the timer build; kept so both builds share
    // one parameter list.
    localparam int unsigned timeout_cyc_unused = TIMEOUT_CYC;

    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_filtr_sekwencer.sv
// ---------------------------------------------------------------------------
// tb_filtr_sekwencer
// Self-checking bench for filtr_sekwencer. The bench plays the filter core
// and coefficient-update roles itself and predicts results from the
// sequencer's externally visible rules: strobe-to-start latency, published
// value, pulse counts, modular sample count and saturating drop count.
// A narrow sample counter is used so that wrap-around is reached quickly.
// ---------------------------------------------------------------------------
module tb_filtr_sekwencer;

    localparam int DW    = 24;
    localparam int CW    = 4;
    localparam int OW    = 8;
    localparam int TMO   = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample;
    logic [DW-1:0] data_in;
    logic          adapt_en;
    logic          ovr_clr;
    logic          filt_start;
    logic [DW-1:0] filt_x;
    logic          filt_done;
    logic [DW-1:0] filt_y;
    logic          adapt_start;
    logic          adapt_done;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;
    logic          overrun;
    logic [OW-1:0] ovr_cnt;
    logic [CW-1:0] sample_cnt;
    logic          err_timeout;

    filtr_sekwencer #(
        .DATA_SIZE   (DW),
        .CNT_W       (CW),
        .OVR_W       (OW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample      (sample),
        .data_in     (data_in),
        .adapt_en    (adapt_en),
        .ovr_clr     (ovr_clr),
        .filt_start  (filt_start),
        .filt_x      (filt_x),
        .filt_done   (filt_done),
        .filt_y      (filt_y),
        .adapt_start (adapt_start),
        .adapt_done  (adapt_done),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .overrun     (overrun),
        .ovr_cnt     (ovr_cnt),
        .sample_cnt  (sample_cnt),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse counters, sampled mid-cycle.
    int fs_cnt = 0;
    int as_cnt = 0;
    int dv_cnt = 0;
    always @(negedge clk) begin
        if (filt_start)  fs_cnt++;
        if (adapt_start) as_cnt++;
        if (data_valid)  dv_cnt++;
    end

    // Reference model state.
    int            exp_cnt;   // samples published since reset
    int            drops;     // strobes dropped since last clear
    logic [DW-1:0] exp_out;   // last published value
    int            txn_no = 0;

    function automatic logic [OW-1:0] exp_ovr();
        return (drops > 255) ? OW'(255) : OW'(drops);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sample = 1'b0; data_in = '0; adapt_en = 1'b0;
        ovr_clr = 1'b0; filt_done = 1'b0; filt_y = '0; adapt_done = 1'b0;
        cyc(2);
        reset = 1'b0;
        exp_cnt = 0; drops = 0; exp_out = '0;
        cyc(4);
    endtask

    // Raise a 2-cycle strobe and wait for filt_start; it must appear on the
    // third negedge after the strobe went high.
    task automatic start_hang(input logic [DW-1:0] x, output bit ok);
        int lat;
        lat = 0;
        @(negedge clk);
        sample = 1'b1; data_in = x;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) sample = 1'b0;
            if (filt_start) begin lat = i; break; end
        end
        total++;
        if (lat != 3 || filt_x !== x) begin
            bad++;
            $display("FAIL start_latency: lat=%0d filt_x=%h, want lat=3 filt_x=%h", lat, filt_x, x);
        end
        sample = 1'b0;
        ok = (lat != 0);
    endtask

    // Complete a pending FILT with adapt_en=0 and check publication.
    task automatic finish_filt(input logic [DW-1:0] y);
        int d0;
        d0 = dv_cnt;
        @(negedge clk);
        filt_done = 1'b1; filt_y = y; adapt_en = 1'b0;
        @(negedge clk);
        filt_done = 1'b0;
        total++;
        if ({data_valid, data_out} !== {1'b1, y}) begin
            bad++;
            $display("FAIL finish_publish: valid=%b out=%h, want valid=1 out=%h", data_valid, data_out, y);
        end
        @(negedge clk);
        exp_cnt++; exp_out = y;
        total++;
        if ({busy, sample_cnt} !== {1'b0, CW'(exp_cnt)} || dv_cnt - d0 != 1) begin
            bad++;
            $display("FAIL finish_state: busy=%b cnt=%0d dv=%0d, want busy=0 cnt=%0d dv=1",
                     busy, sample_cnt, dv_cnt - d0, CW'(exp_cnt));
        end
    endtask

    // One complete sample with core delay fdly and optional update (delay adly).
    task automatic run_txn(input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input int fdly, input bit aen, input int adly);
        int f0, a0, d0, t;
        bit ok;
        f0 = fs_cnt; a0 = as_cnt; d0 = dv_cnt;
        txn_no++;
        $display("txn %0d: x=%h y=%h fdly=%0d aen=%0d adly=%0d", txn_no, x, y, fdly, aen, adly);
        adapt_en = ~aen;   // only the value on the filt_done cycle may matter
        start_hang(x, ok);
        if (!ok) begin do_reset(); return; end
        @(negedge clk);
        repeat (fdly) @(negedge clk);
        filt_done = 1'b1; filt_y = y; adapt_en = aen;
        t = 4 + fdly;
        @(negedge clk);
        filt_done = 1'b0; filt_y = DW'($urandom); adapt_en = ~aen; t++;
        total++;
        if (data_out !== y) begin
            bad++;
            $display("FAIL txn_data_out: got %h want %h", data_out, y);
        end
        if (aen) begin
            total++;
            if (adapt_start !== 1'b1) begin
                bad++;
                $display("FAIL txn_adapt_start: got %b want 1", adapt_start);
            end
            repeat (adly) @(negedge clk);
            adapt_done = 1'b1;
            @(negedge clk);
            adapt_done = 1'b0;
            t += adly + 1;
        end
        total++;
        if (data_valid !== 1'b1 || t != (aen ? 6 + fdly + adly : 5 + fdly)) begin
            bad++;
            $display("FAIL txn_valid_latency: valid=%b t=%0d, want valid=1 t=%0d",
                     data_valid, t, aen ? 6 + fdly + adly : 5 + fdly);
        end
        @(negedge clk);
        exp_cnt++; exp_out = y;
        total++;
        if ({busy, sample_cnt} !== {1'b0, CW'(exp_cnt)}) begin
            bad++;
            $display("FAIL txn_count: busy=%b cnt=%0d, want busy=0 cnt=%0d", busy, sample_cnt, CW'(exp_cnt));
        end
        total++;
        if (fs_cnt - f0 != 1 || as_cnt - a0 != int'(aen) || dv_cnt - d0 != 1) begin
            bad++;
            $display("FAIL txn_pulses: fs=%0d as=%0d dv=%0d, want fs=1 as=%0d dv=1",
                     fs_cnt - f0, as_cnt - a0, dv_cnt - d0, aen);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({filt_start, filt_x, adapt_start, data_out, data_valid, busy, overrun,
             ovr_cnt, sample_cnt, err_timeout} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: x=%h out=%h busy=%b ovr=%b/%0d cnt=%0d tmo=%b, want all 0",
                     filt_x, data_out, busy, overrun, ovr_cnt, sample_cnt, err_timeout);
        end
    endtask

    task automatic test_basic();
        run_txn(24'h0A1B2C, 24'h000123, 10, 1'b0, 0);
        run_txn(24'h0A1B2C, 24'h000123, 10, 1'b1, 20);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] x1, x2, y1, y2;
        x1 = DW'($urandom); x2 = DW'($urandom); y1 = DW'($urandom); y2 = DW'($urandom);
        $display("txn b2b: x1=%h x2=%h", x1, x2);
        @(negedge clk); sample = 1'b1; data_in = x1; adapt_en = 1'b0;   // N0
        cyc(2); sample = 1'b0;                                          // N2
        @(negedge clk);                                                 // N3
        total++;
        if ({filt_start, filt_x} !== {1'b1, x1}) begin
            bad++;
            $display("FAIL b2b_first_load: start=%b x=%h, want 1 %h", filt_start, filt_x, x1);
        end
        sample = 1'b1; data_in = x2;
        @(negedge clk); filt_done = 1'b1; filt_y = y1;                  // N4
        @(negedge clk); filt_done = 1'b0; sample = 1'b0;                // N5
        total++;
        if ({data_valid, data_out} !== {1'b1, y1}) begin
            bad++;
            $display("FAIL b2b_first_out: valid=%b out=%h, want 1 %h", data_valid, data_out, y1);
        end
        @(negedge clk);                                                 // N6
        exp_cnt++;
        total++;
        if ({filt_start, filt_x, overrun} !== {1'b1, x2, 1'b0}) begin
            bad++;
            $display("FAIL b2b_second_load: start=%b x=%h ovr=%b, want 1 %h 0", filt_start, filt_x, overrun, x2);
        end
        @(negedge clk); filt_done = 1'b1; filt_y = y2;
        @(negedge clk); filt_done = 1'b0;
        total++;
        if ({data_valid, data_out} !== {1'b1, y2}) begin
            bad++;
            $display("FAIL b2b_second_out: valid=%b out=%h, want 1 %h", data_valid, data_out, y2);
        end
        @(negedge clk);
        exp_cnt++; exp_out = y2;
        total++;
        if ({busy, sample_cnt} !== {1'b0, CW'(exp_cnt)}) begin
            bad++;
            $display("FAIL b2b_count: busy=%b cnt=%0d, want 0 %0d", busy, sample_cnt, CW'(exp_cnt));
        end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [DW-1:0] x;
        x = DW'($urandom);
        $display("txn overrun: x=%h", x);
        start_hang(x, ok);
        @(negedge clk); sample = 1'b1; data_in = ~x;
        cyc(2); sample = 1'b0;
        drops++;
        cyc(300);
        total++;
        if ({overrun, ovr_cnt, filt_x, busy} !== {1'b1, exp_ovr(), x, 1'b1}) begin
            bad++;
            $display("FAIL overrun_flag: ovr=%b cnt=%0d x=%h busy=%b, want 1 %0d %h 1",
                     overrun, ovr_cnt, filt_x, busy, exp_ovr(), x);
        end
        // Third strobe whose rise lands on the ovr_clr cycle: clear wins.
        @(negedge clk); sample = 1'b1;
        cyc(2); sample = 1'b0; ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        drops = 0;
        total++;
        if ({overrun, ovr_cnt} !== {1'b0, exp_ovr()}) begin
            bad++;
            $display("FAIL overrun_clr_wins: ovr=%b cnt=%0d, want 0 0", overrun, ovr_cnt);
        end
        finish_filt(DW'($urandom));
    endtask

    task automatic test_saturation();
        bit ok;
        $display("txn saturation: 300 dropped strobes");
        start_hang(DW'($urandom), ok);
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk); sample = 1'b1;
            cyc(2); sample = 1'b0;
            cyc(1);
            drops++;
            if (i == 10 || i == 255 || i == 300) begin
                total++;
                if (ovr_cnt !== exp_ovr()) begin
                    bad++;
                    $display("FAIL ovr_cnt_sat at %0d: got %0d want %0d", i, ovr_cnt, exp_ovr());
                end
            end
        end
        finish_filt(DW'($urandom));
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        drops = 0;
        total++;
        if ({overrun, ovr_cnt} !== {1'b0, exp_ovr()}) begin
            bad++;
            $display("FAIL ovr_clear: ovr=%b cnt=%0d, want 0 0", overrun, ovr_cnt);
        end
    endtask

    task automatic test_ignored_done();
        bit ok;
        int d0;
        d0 = dv_cnt;
        $display("txn ignored_done");
        @(negedge clk); filt_done = 1'b1; adapt_done = 1'b1; filt_y = ~exp_out;
        @(negedge clk); filt_done = 1'b0; adapt_done = 1'b0;
        cyc(2);
        total++;
        if ({busy, data_out} !== {1'b0, exp_out} || dv_cnt != d0) begin
            bad++;
            $display("FAIL idle_done_ignored: busy=%b out=%h dv=%0d, want 0 %h 0", busy, data_out, dv_cnt - d0, exp_out);
        end
        start_hang(DW'($urandom), ok);
        cyc(2);
        @(negedge clk); adapt_done = 1'b1;
        @(negedge clk); adapt_done = 1'b0;
        cyc(2);
        total++;
        if (busy !== 1'b1 || dv_cnt != d0) begin
            bad++;
            $display("FAIL filt_adapt_done_ignored: busy=%b dv=%0d, want 1 0", busy, dv_cnt - d0);
        end
        finish_filt(DW'($urandom));
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_txn(DW'($urandom), DW'($urandom), $urandom_range(0, 5),
                    1'($urandom_range(0, 1)), $urandom_range(1, 5));
    endtask

    task automatic test_timeout();
        bit ok;
        int n, d0;
        logic [CW-1:0] cnt0;
        d0 = dv_cnt; cnt0 = sample_cnt;
        $display("txn timeout: filt_done withheld");
        start_hang(DW'($urandom), ok);
`ifdef FILTR_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        total++;
        if (n != TMO || err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire: cycles=%0d tmo=%b, want %0d 1", n, err_timeout, TMO);
        end
        total++;
        if (dv_cnt != d0 || data_out !== exp_out || sample_cnt !== cnt0) begin
            bad++;
            $display("FAIL timeout_no_publish: dv=%0d out=%h cnt=%0d, want 0 %h %0d",
                     dv_cnt - d0, data_out, sample_cnt, exp_out, cnt0);
        end
`else
        n = 5000;
        cyc(n);
        total++;
        if ({busy, err_timeout} !== 2'b10 || dv_cnt != d0) begin
            bad++;
            $display("FAIL no_timeout_wait: busy=%b tmo=%b dv=%0d, want 1 0 0", busy, err_timeout, dv_cnt - d0);
        end
        finish_filt(DW'($urandom));
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        $display("txn reset_mid");
        start_hang(DW'($urandom), ok);
        @(negedge clk); filt_done = 1'b1; filt_y = DW'($urandom); adapt_en = 1'b1;
        @(negedge clk); filt_done = 1'b0;
        total++;
        if (adapt_start !== 1'b1) begin
            bad++;
            $display("FAIL mid_adapt_start: got %b want 1", adapt_start);
        end
        cyc(3);
        reset = 1'b1;
        #1;
        total++;
        if ({filt_start, filt_x, adapt_start, data_out, data_valid, busy, overrun,
             ovr_cnt, sample_cnt, err_timeout} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: x=%h out=%h busy=%b cnt=%0d adapt=%b, want all 0",
                     filt_x, data_out, busy, sample_cnt, adapt_start);
        end
        @(negedge clk); reset = 1'b0; adapt_en = 1'b0;
        exp_cnt = 0; drops = 0; exp_out = '0;
        cyc(2);
        run_txn(DW'($urandom), DW'($urandom), 2, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b1; sample = 1'b0; data_in = '0; adapt_en = 1'b0;
        ovr_clr = 1'b0; filt_done = 1'b0; filt_y = '0; adapt_done = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_saturation();
        test_ignored_done();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
